// File: rtl/utf8_tx_encoder.sv
// UTF-8 encoder feeding a byte-wide UART transmitter: one BMP code point in,
// 1-3 encoded bytes (optionally followed by CR LF) out as single-cycle tx_en pulses.
module utf8_tx_encoder #(
    parameter bit APPEND_CRLF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cp_in,
    input  logic        cp_valid,
    output logic        cp_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_sending,
    output logic        subst
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  buf_q [5];
    logic [7:0]  buf_d [5];
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        subst_q, subst_d;

    logic        accept;
    logic        surrogate;
    logic        fire;
    logic [7:0]  enc [5];
    logic [2:0]  enc_n;

    assign cp_ready  = (state_q == IDLE) && !rst;
    assign accept    = cp_valid && cp_ready;
    assign surrogate = (cp_in[15:11] == 5'b11011);
    assign fire      = (state_q == EMIT) && !tx_sending && !tx_en_q;

    // Lead byte lands in enc[0]; the buffer shifts toward index 0 as bytes go out.
    always_comb begin
        for (int unsigned i = 0; i < 5; i++) enc[i] = '0;
        enc_n = 3'd1;
        if (surrogate) begin
            enc[0] = 8'hEF;
            enc[1] = 8'hBF;
            enc[2] = 8'hBD;
            enc_n  = 3'd3;
        end else if (cp_in[15:7] == '0) begin
            enc[0] = {1'b0, cp_in[6:0]};
            enc_n  = 3'd1;
        end else if (cp_in[15:11] == '0) begin
            enc[0] = {3'b110, cp_in[10:6]};
            enc[1] = {2'b10, cp_in[5:0]};
            enc_n  = 3'd2;
        end else begin
            enc[0] = {4'b1110, cp_in[15:12]};
            enc[1] = {2'b10, cp_in[11:6]};
            enc[2] = {2'b10, cp_in[5:0]};
            enc_n  = 3'd3;
        end
        if (APPEND_CRLF) begin
            case (enc_n)
                3'd1:    begin enc[1] = 8'h0D; enc[2] = 8'h0A; end
                3'd2:    begin enc[2] = 8'h0D; enc[3] = 8'h0A; end
                default: begin enc[3] = 8'h0D; enc[4] = 8'h0A; end
            endcase
            enc_n = enc_n + 3'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            subst_q   <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            subst_q   <= subst_d;
            for (int unsigned i = 0; i < 5; i++) buf_q[i] <= buf_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EMIT;
            EMIT:    if (fire) state_d = GAP;
            GAP:     state_d = (cnt_q == '0) ? IDLE : EMIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) buf_d[i] = buf_q[i];
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        subst_d   = 1'b0;
        if (accept) begin
            for (int unsigned i = 0; i < 5; i++) buf_d[i] = enc[i];
            cnt_d   = enc_n;
            subst_d = surrogate;
        end else if (fire) begin
            tx_data_d = buf_q[0];
            tx_en_d   = 1'b1;
            cnt_d     = cnt_q - 3'd1;
            for (int unsigned i = 0; i < 4; i++) buf_d[i] = buf_q[i+1];
            buf_d[4] = '0;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign subst   = subst_q;

endmodule

// File: tb/tb_utf8_tx_encoder.sv
// Scoreboard bench for utf8_tx_encoder: one instance without and one with CR LF appended.
module tb_utf8_tx_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cp_in;
    logic        cp_valid0, cp_valid1;
    logic        tx_sending;
    logic        cp_ready0, cp_ready1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_en0, tx_en1;
    logic        subst0, subst1;

    int checks = 0;
    int failures = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int sub_cnt0 = 0, sub_cnt1 = 0;
    int en_cnt0 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;

    always #5 clk = ~clk;

    utf8_tx_encoder #(.APPEND_CRLF(1'b0)) u0 (
        .clk(clk), .rst(rst), .cp_in(cp_in), .cp_valid(cp_valid0), .cp_ready(cp_ready0),
        .tx_data(tx_data0), .tx_en(tx_en0), .tx_sending(tx_sending), .subst(subst0)
    );

    utf8_tx_encoder #(.APPEND_CRLF(1'b1)) u1 (
        .clk(clk), .rst(rst), .cp_in(cp_in), .cp_valid(cp_valid1), .cp_ready(cp_ready1),
        .tx_data(tx_data1), .tx_en(tx_en1), .tx_sending(tx_sending), .subst(subst1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding built straight from the UTF-8 bit layouts.
    task automatic exp_push(input bit which, input logic [15:0] cp);
        logic [7:0] b [5];
        int n;
        if (cp >= 16'hD800 && cp <= 16'hDFFF) begin
            b[0] = 8'hEF; b[1] = 8'hBF; b[2] = 8'hBD; n = 3;
        end else if (cp < 16'h0080) begin
            b[0] = cp[7:0]; n = 1;
        end else if (cp < 16'h0800) begin
            b[0] = 8'hC0 | {3'b000, cp[10:6]};
            b[1] = 8'h80 | {2'b00, cp[5:0]};
            n = 2;
        end else begin
            b[0] = 8'hE0 | {4'b0000, cp[15:12]};
            b[1] = 8'h80 | {2'b00, cp[11:6]};
            b[2] = 8'h80 | {2'b00, cp[5:0]};
            n = 3;
        end
        if (which) begin
            b[n] = 8'h0D; b[n+1] = 8'h0A; n = n + 2;
        end
        for (int i = 0; i < n; i++) begin
            if (which) q1.push_back(b[i]);
            else       q0.push_back(b[i]);
        end
    endtask

    always @(negedge clk) begin
        if (tx_en0) begin
            en_cnt0++;
            check("en_gap0", {31'd0, prev0}, 32'd0);
            if (q0.size() == 0) check("unexp_tx0", {31'd0, tx_en0}, 32'd0);
            else                check("byte0", {24'd0, tx_data0}, {24'd0, q0.pop_front()});
        end
        if (tx_en1) begin
            check("en_gap1", {31'd0, prev1}, 32'd0);
            if (q1.size() == 0) check("unexp_tx1", {31'd0, tx_en1}, 32'd0);
            else                check("byte1", {24'd0, tx_data1}, {24'd0, q1.pop_front()});
        end
        if (subst0) sub_cnt0++;
        if (subst1) sub_cnt1++;
        prev0 = tx_en0;
        prev1 = tx_en1;
    end

    task automatic wait_ready(input bit which);
        int t = 0;
        while (!(which ? cp_ready1 : cp_ready0) && t < 100) begin
            @(negedge clk); t++;
        end
        check("ready", {31'd0, which ? cp_ready1 : cp_ready0}, 32'd1);
    endtask

    task automatic drain(input bit which, input int exp_sub);
        int t = 0;
        while (((which ? q1.size() : q0.size()) != 0 || !(which ? cp_ready1 : cp_ready0)) && t < 400) begin
            @(negedge clk); t++;
        end
        check("drain", (which ? q1.size() : q0.size()), 32'd0);
        check("subst_cnt", (which ? sub_cnt1 : sub_cnt0), exp_sub);
    endtask

    task automatic accept_cp(input bit which, input logic [15:0] cp);
        wait_ready(which);
        sub_cnt0 = 0; sub_cnt1 = 0;
        cp_in = cp;
        if (which) cp_valid1 = 1'b1; else cp_valid0 = 1'b1;
        exp_push(which, cp);
        @(negedge clk);
        cp_valid0 = 1'b0; cp_valid1 = 1'b0;
        check("busy", {31'd0, which ? cp_ready1 : cp_ready0}, 32'd0);
        @(negedge clk);
        check("latency", {31'd0, which ? tx_en1 : tx_en0}, 32'd1);
    endtask

    task automatic send(input bit which, input logic [15:0] cp);
        accept_cp(which, cp);
        drain(which, (cp >= 16'hD800 && cp <= 16'hDFFF) ? 1 : 0);
    endtask

    initial begin
        int t;
        int cnt;
        logic [15:0] r;
        rst = 1'b1; cp_in = '0; cp_valid0 = 1'b0; cp_valid1 = 1'b0; tx_sending = 1'b0;
        repeat (3) @(negedge clk);
        cp_valid0 = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, cp_ready0}, 32'd0);
        check("rst_en", {31'd0, tx_en0}, 32'd0);
        check("rst_data", {24'd0, tx_data0}, 32'd0);
        check("rst_subst", {31'd0, subst0}, 32'd0);
        cp_valid0 = 1'b0;
        rst = 1'b0;
        #1 check("ready_after_rst", {31'd0, cp_ready0}, 32'd1);
        @(negedge clk);

        send(0, 16'h0E01);
        check("ready_after", {31'd0, cp_ready0}, 32'd1);
        send(0, 16'h0041);
        send(0, 16'h00E9);
        send(0, 16'hD800);
        send(0, 16'hDFFF);
        send(0, 16'h007F);
        send(0, 16'h0080);
        send(0, 16'h07FF);
        send(0, 16'h0800);
        send(0, 16'hFFFF);
        send(0, 16'h0000);

        // CR LF instance: ready must stay low until after the LF pulse
        accept_cp(1, 16'h0E01);
        t = 0;
        while (q1.size() != 0 && t < 100) begin
            check("crlf_busy", {31'd0, cp_ready1}, 32'd0);
            @(negedge clk); t++;
        end
        drain(1, 0);
        send(1, 16'h0041);
        send(1, 16'hDABC);

        // cp_valid while busy must be ignored
        accept_cp(0, 16'h20AC);
        cp_in = 16'h0030; cp_valid0 = 1'b1;
        repeat (3) @(negedge clk);
        cp_valid0 = 1'b0;
        drain(0, 0);

        // Tx back-pressure after the lead byte
        sub_cnt0 = 0;
        accept_cp(0, 16'h0E01);
        tx_sending = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_en0) cnt++;
        end
        check("hold_no_en", cnt, 32'd0);
        check("hold_data", {24'd0, tx_data0}, 32'hE0);
        check("hold_q", q0.size(), 32'd2);
        tx_sending = 1'b0;
        @(negedge clk);
        check("release_en", {31'd0, tx_en0}, 32'd1);
        drain(0, 0);

        // Reset after the second byte aborts the rest
        wait_ready(0);
        cp_in = 16'h0E01; cp_valid0 = 1'b1;
        q0.push_back(8'hE0); q0.push_back(8'hB8);
        en_cnt0 = 0;
        @(negedge clk);
        cp_valid0 = 1'b0;
        t = 0;
        while (en_cnt0 < 2 && t < 50) begin
            @(negedge clk); t++;
        end
        check("second_byte", en_cnt0, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_en", {31'd0, tx_en0}, 32'd0);
        check("abort_data", {24'd0, tx_data0}, 32'd0);
        check("abort_ready", {31'd0, cp_ready0}, 32'd0);
        rst = 1'b0;
        cnt = en_cnt0;
        repeat (10) @(negedge clk);
        check("abort_silent", en_cnt0, cnt);
        send(0, 16'h0041);

        for (int i = 0; i < 24; i++) begin
            r = 16'($urandom);
            case (i % 4)
                0: r = r & 16'h007F;
                1: r = r & 16'h07FF;
                default: ;
            endcase
            send(i % 5 == 0, r);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
